// File: rtl/ring_shift_pkg.sv
// Shared types and constants for the ring/Johnson shift counter.
package ring_shift_pkg;

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int SEED_W = 64;

  // 0...01 is legal in both ring and Johnson modes.
  function automatic logic [SEED_W-1:0] ring_seed(int width);
    return (width >= 1) ? SEED_W'(1) : '0;
  endfunction

  function automatic int ring_period(mode_e mode, int width);
    return (mode == MODE_JOHNSON) ? 2 * width : width;
  endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check of the counter state for the active mode.
module ring_state_check
  import ring_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal
);

  int edges;
  logic onehot;

  always_comb begin
    edges = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + int'(q[i] ^ q[i+1]);
    end
    onehot = ($countones(q) == 1);
    legal = (mode == MODE_JOHNSON) ? (edges <= 1) : onehot;
  end

endmodule

// File: rtl/ring_shift_ctr.sv
// One-hot ring / Johnson counter with direction, load and position index.
// Define RING_SHIFT_SELFCORRECT_EN to build illegal-state recovery.
module ring_shift_ctr
  import ring_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] SEED =
    WIDTH'(ring_seed(WIDTH));
  localparam logic [IDX_W-1:0] LAST_RING =
    IDX_W'(ring_period(MODE_RING, WIDTH) - 1);
  localparam logic [IDX_W-1:0] LAST_JOHN =
    IDX_W'(ring_period(MODE_JOHNSON, WIDTH) - 1);

  logic             mode_q;
  logic             mode_n;
  logic [WIDTH-1:0] q_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W-1:0] last;
  logic             wrap_n;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] v,
    input logic             m,
    input logic             d
  );
    logic [WIDTH-1:0] r;
    unique case ({m, d})
      2'b00:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      2'b01:   r = {v[0], v[WIDTH-1:1]};
      2'b10:   r = {v[WIDTH-2:0], ~v[WIDTH-1]};
      default: r = {~v[0], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

`ifdef RING_SHIFT_SELFCORRECT_EN
  logic legal;
  logic recover;
  logic ill_n;

  ring_state_check #(
    .WIDTH(WIDTH)
  ) u_check (
    .q    (q),
    .mode (mode_q),
    .legal(legal)
  );

  assign recover = ~legal;

  always_ff @(posedge clk) begin
    if (reset) illegal <= 1'b0;
    else       illegal <= ill_n;
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    q_n    = q;
    idx_n  = idx;
    mode_n = mode_q;
    wrap_n = 1'b0;
`ifdef RING_SHIFT_SELFCORRECT_EN
    ill_n  = 1'b0;
`endif
    last = (mode_q == MODE_JOHNSON) ? LAST_JOHN : LAST_RING;
    if (load) begin
      q_n   = load_val;
      idx_n = '0;
    end
`ifdef RING_SHIFT_SELFCORRECT_EN
    else if (recover) begin
      q_n   = SEED;
      idx_n = '0;
      ill_n = 1'b1;
    end
`endif
    else if (mode != mode_q) begin
      // Index restarts; q still steps once under the new mode.
      mode_n = mode;
      idx_n  = '0;
      if (en) q_n = step(q, mode, dir);
    end else if (en) begin
      q_n = step(q, mode_q, dir);
      if (dir == DIR_RIGHT) begin
        if (idx == '0) begin
          idx_n  = last;
          wrap_n = 1'b1;
        end else begin
          idx_n = idx - 1'b1;
        end
      end else if (idx == last) begin
        idx_n  = '0;
        wrap_n = 1'b1;
      end else begin
        idx_n = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= SEED;
      idx    <= '0;
      wrap   <= 1'b0;
      mode_q <= MODE_RING;
    end else begin
      q      <= q_n;
      idx    <= idx_n;
      wrap   <= wrap_n;
      mode_q <= mode_n;
    end
  end

endmodule

// File: tb/tb_ring_shift_ctr.sv
// Scoreboard bench for ring_shift_ctr (WIDTH=4 and WIDTH=7 instances).
// Expectations follow RING_SHIFT_SELFCORRECT_EN when it is defined.
module tb_ring_shift_ctr;

  typedef logic [8:0]  stim4_t;
  typedef logic [8:0]  exp4_t;
  typedef logic [11:0] stim7_t;
  typedef logic [12:0] exp7_t;

  logic       clk;
  logic       reset, en, mode, dir, load;
  logic [3:0] load_val;
  logic [3:0] q4;
  logic [2:0] idx4;
  logic       wrap4, ill4;

  logic       reset7, en7, mode7, dir7, load7;
  logic [6:0] load_val7;
  logic [6:0] q7;
  logic [3:0] idx7;
  logic       wrap7, ill7;

  stim4_t st4[$];
  exp4_t  sb4[$];
  stim7_t st7[$];
  exp7_t  sb7[$];

  int n_tests = 0;
  int n_fail  = 0;

  ring_shift_ctr #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .q(q4), .idx(idx4),
    .wrap(wrap4), .illegal(ill4)
  );

  ring_shift_ctr #(.WIDTH(7)) dut7 (
    .clk(clk), .reset(reset7), .en(en7), .mode(mode7), .dir(dir7),
    .load(load7), .load_val(load_val7), .q(q7), .idx(idx7),
    .wrap(wrap7), .illegal(ill7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim4_t s4(input logic r, e, m, d, l,
                                input logic [3:0] lv);
    return {r, e, m, d, l, lv};
  endfunction

  function automatic exp4_t x4(input logic [3:0] qv, input int iv,
                               input logic w, input logic il);
    logic [2:0] i3;
    i3 = iv[2:0];
    return {qv, i3, w, il};
  endfunction

  task automatic plan4(input stim4_t s, input exp4_t x);
    st4.push_back(s);
    sb4.push_back(x);
  endtask

  task automatic cyc4(input stim4_t s);
    {reset, en, mode, dir, load, load_val} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp4_t got, want;
    int k = 0;
    plan4(s4(1, 1, 1, 1, 1, 4'b1010), x4(4'b0001, 0, 0, 0));
    plan4(s4(1, 0, 0, 0, 0, 4'b0000), x4(4'b0001, 0, 0, 0));
    while (st4.size() > 0) begin
      cyc4(st4.pop_front());
      want = sb4.pop_front();
      got = {q4, idx4, wrap4, ill4};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset[%0d]: got q=%b idx=%0d wrap=%b ill=%b, expected q=%b idx=%0d wrap=%b ill=%b",
                 k, got[8:5], got[4:2], got[1], got[0],
                 want[8:5], want[4:2], want[1], want[0]);
      end
      k++;
    end
  endtask

  task automatic test_ring_left();
    exp4_t got, want;
    int k = 0;
    plan4(s4(1, 0, 0, 0, 0, 0), x4(4'b0001, 0, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0010, 1, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0100, 2, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b1000, 3, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0001, 0, 1, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0010, 1, 0, 0));
    while (st4.size() > 0) begin
      cyc4(st4.pop_front());
      want = sb4.pop_front();
      got = {q4, idx4, wrap4, ill4};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL ring_left[%0d]: got q=%b idx=%0d wrap=%b ill=%b, expected q=%b idx=%0d wrap=%b ill=%b",
                 k, got[8:5], got[4:2], got[1], got[0],
                 want[8:5], want[4:2], want[1], want[0]);
      end
      k++;
    end
  endtask

  task automatic test_johnson_left();
    exp4_t got, want;
    int k = 0;
    plan4(s4(1, 0, 0, 0, 0, 0), x4(4'b0001, 0, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0011, 0, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0111, 1, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b1111, 2, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b1110, 3, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b1100, 4, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b1000, 5, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0000, 6, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0001, 7, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0011, 0, 1, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0111, 1, 0, 0));
    while (st4.size() > 0) begin
      cyc4(st4.pop_front());
      want = sb4.pop_front();
      got = {q4, idx4, wrap4, ill4};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL johnson_left[%0d]: got q=%b idx=%0d wrap=%b ill=%b, expected q=%b idx=%0d wrap=%b ill=%b",
                 k, got[8:5], got[4:2], got[1], got[0],
                 want[8:5], want[4:2], want[1], want[0]);
      end
      k++;
    end
  endtask

  task automatic test_ring_right_hold();
    exp4_t got, want;
    int k = 0;
    plan4(s4(1, 0, 0, 0, 0, 0), x4(4'b0001, 0, 0, 0));
    plan4(s4(0, 1, 0, 1, 0, 0), x4(4'b1000, 3, 1, 0));
    plan4(s4(0, 1, 0, 1, 0, 0), x4(4'b0100, 2, 0, 0));
    plan4(s4(0, 0, 0, 1, 0, 0), x4(4'b0100, 2, 0, 0));
    plan4(s4(0, 0, 0, 0, 0, 0), x4(4'b0100, 2, 0, 0));
    plan4(s4(0, 0, 0, 1, 0, 0), x4(4'b0100, 2, 0, 0));
    plan4(s4(0, 1, 0, 1, 0, 0), x4(4'b0010, 1, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0100, 2, 0, 0));
    while (st4.size() > 0) begin
      cyc4(st4.pop_front());
      want = sb4.pop_front();
      got = {q4, idx4, wrap4, ill4};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL ring_right[%0d]: got q=%b idx=%0d wrap=%b ill=%b, expected q=%b idx=%0d wrap=%b ill=%b",
                 k, got[8:5], got[4:2], got[1], got[0],
                 want[8:5], want[4:2], want[1], want[0]);
      end
      k++;
    end
  endtask

  task automatic test_load_illegal();
    exp4_t got, want;
    int k = 0;
    plan4(s4(1, 0, 0, 0, 0, 0), x4(4'b0001, 0, 0, 0));
    plan4(s4(0, 0, 0, 0, 1, 4'b0110), x4(4'b0110, 0, 0, 0));
`ifdef RING_SHIFT_SELFCORRECT_EN
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0001, 0, 0, 1));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0010, 1, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0100, 2, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b1000, 3, 0, 0));
`else
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b1100, 1, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b1001, 2, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0011, 3, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0110, 0, 1, 0));
`endif
    while (st4.size() > 0) begin
      cyc4(st4.pop_front());
      want = sb4.pop_front();
      got = {q4, idx4, wrap4, ill4};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_illegal[%0d]: got q=%b idx=%0d wrap=%b ill=%b, expected q=%b idx=%0d wrap=%b ill=%b",
                 k, got[8:5], got[4:2], got[1], got[0],
                 want[8:5], want[4:2], want[1], want[0]);
      end
      k++;
    end
  endtask

  task automatic test_mode_change();
    exp4_t got, want;
    int k = 0;
    plan4(s4(1, 0, 0, 0, 0, 0), x4(4'b0001, 0, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0010, 1, 0, 0));
    plan4(s4(0, 1, 0, 0, 0, 0), x4(4'b0100, 2, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b1001, 0, 0, 0));
`ifdef RING_SHIFT_SELFCORRECT_EN
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0001, 0, 0, 1));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0011, 1, 0, 0));
    plan4(s4(0, 0, 0, 0, 0, 0), x4(4'b0011, 0, 0, 0));
    plan4(s4(0, 0, 0, 0, 0, 0), x4(4'b0001, 0, 0, 1));
`else
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0010, 1, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0101, 2, 0, 0));
    plan4(s4(0, 0, 0, 0, 0, 0), x4(4'b0101, 0, 0, 0));
    plan4(s4(0, 0, 0, 0, 0, 0), x4(4'b0101, 0, 0, 0));
`endif
    while (st4.size() > 0) begin
      cyc4(st4.pop_front());
      want = sb4.pop_front();
      got = {q4, idx4, wrap4, ill4};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mode_change[%0d]: got q=%b idx=%0d wrap=%b ill=%b, expected q=%b idx=%0d wrap=%b ill=%b",
                 k, got[8:5], got[4:2], got[1], got[0],
                 want[8:5], want[4:2], want[1], want[0]);
      end
      k++;
    end
  endtask

  task automatic test_load_priority();
    exp4_t got, want;
    int k = 0;
    plan4(s4(1, 0, 0, 0, 0, 0), x4(4'b0001, 0, 0, 0));
    plan4(s4(0, 1, 1, 0, 1, 4'b0011), x4(4'b0011, 0, 0, 0));
`ifdef RING_SHIFT_SELFCORRECT_EN
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0001, 0, 0, 1));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0011, 0, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0111, 1, 0, 0));
`else
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b0111, 0, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b1111, 1, 0, 0));
    plan4(s4(0, 1, 1, 0, 0, 0), x4(4'b1110, 2, 0, 0));
`endif
    while (st4.size() > 0) begin
      cyc4(st4.pop_front());
      want = sb4.pop_front();
      got = {q4, idx4, wrap4, ill4};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_priority[%0d]: got q=%b idx=%0d wrap=%b ill=%b, expected q=%b idx=%0d wrap=%b ill=%b",
                 k, got[8:5], got[4:2], got[1], got[0],
                 want[8:5], want[4:2], want[1], want[0]);
      end
      k++;
    end
  endtask

  task automatic test_width7();
    exp7_t got, want;
    stim7_t s;
    int k = 0;
    st7.push_back({5'b10000, 7'd0});
    sb7.push_back({7'b0000001, 4'd0, 2'b00});
    for (int i = 1; i <= 5; i++) begin
      logic [6:0] oh;
      logic [3:0] iv;
      oh = 7'b0000001 << i;
      iv = 4'(i);
      st7.push_back({5'b01000, 7'd0});
      sb7.push_back({oh, iv, 2'b00});
    end
    st7.push_back({5'b11101, 7'b1010101});
    sb7.push_back({7'b0000001, 4'd0, 2'b00});
    st7.push_back({5'b01010, 7'd0});
    sb7.push_back({7'b1000000, 4'd6, 2'b10});
    while (st7.size() > 0) begin
      s = st7.pop_front();
      {reset7, en7, mode7, dir7, load7, load_val7} = s;
      @(posedge clk);
      #1;
      want = sb7.pop_front();
      got = {q7, idx7, wrap7, ill7};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL width7[%0d]: got q=%b idx=%0d wrap=%b ill=%b, expected q=%b idx=%0d wrap=%b ill=%b",
                 k, got[12:6], got[5:2], got[1], got[0],
                 want[12:6], want[5:2], want[1], want[0]);
      end
      k++;
    end
  endtask

  initial begin
    {reset, en, mode, dir, load, load_val} = {5'b10000, 4'd0};
    {reset7, en7, mode7, dir7, load7, load_val7} = {5'b10000, 7'd0};
    test_reset();
    test_ring_left();
    test_johnson_left();
    test_ring_right_hold();
    test_load_illegal();
    test_mode_change();
    test_load_priority();
    test_width7();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
